// File: rtl/ysyx_rob_commit.sv
// ---------------------------------------------------------------------------
// ysyx_rob_commit
//
// In-order reorder buffer and commit stage. The buffer allocates one tag per
// dispatched instruction, captures EXU writebacks out of order, answers
// operand-readiness lookups for the reservation stations, and retires
// entries strictly in program order toward the register file / CSR unit.
// A retiring entry that carries pc_change produces a one-cycle redirect and
// empties the whole buffer on the same edge.
//
// Tags: 0 means "no producer"; tags 1..ROB_SIZE name entries 0..ROB_SIZE-1.
//
// Optional build macro:
//   YSYX_ROB_WB_BYPASS_EN - when defined, a lookup that hits the tag being
//   written back this cycle (target entry BUSY) reports ready with wb_result
//   combinationally. When undefined, readiness follows registered DONE state
//   only and appears one cycle after the writeback.
//
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   dis_*                   dispatch handshake, payload and allocated tag
//   wb_*                    EXU writeback (tag + result/next-PC/CSR fields)
//   lk1_*, lk2_*            combinational operand lookups
//   cm_*                    registered commit outputs, cm_valid is a pulse
//   flush_valid/flush_npc   registered redirect, coincident with cm_valid
//   rob_empty               buffer holds no entries
// ---------------------------------------------------------------------------
module ysyx_rob_commit #(
  parameter int ROB_SIZE = 4,
  parameter int XLEN     = 32,
  parameter int TAG_W    = $clog2(ROB_SIZE) + 1
) (
  input  logic             clock,
  input  logic             reset,
  // dispatch
  input  logic             dis_valid,
  output logic             dis_ready,
  input  logic [4:0]       dis_rd,
  input  logic [XLEN-1:0]  dis_pc,
  input  logic [31:0]      dis_inst,
  output logic [TAG_W-1:0] dis_dest,
  // writeback
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_dest,
  input  logic [XLEN-1:0]  wb_result,
  input  logic [XLEN-1:0]  wb_npc,
  input  logic             wb_pc_change,
  input  logic             wb_ebreak,
  input  logic             wb_csr_wen,
  input  logic [11:0]      wb_csr_addr,
  input  logic [XLEN-1:0]  wb_csr_wdata,
  // operand lookups
  input  logic [TAG_W-1:0] lk1_tag,
  input  logic [TAG_W-1:0] lk2_tag,
  output logic             lk1_ready,
  output logic             lk2_ready,
  output logic [XLEN-1:0]  lk1_value,
  output logic [XLEN-1:0]  lk2_value,
  // commit
  output logic             cm_valid,
  output logic [4:0]       cm_rd,
  output logic [XLEN-1:0]  cm_result,
  output logic [XLEN-1:0]  cm_pc,
  output logic [31:0]      cm_inst,
  output logic             cm_csr_wen,
  output logic [11:0]      cm_csr_addr,
  output logic [XLEN-1:0]  cm_csr_wdata,
  output logic             cm_ebreak,
  output logic             flush_valid,
  output logic [XLEN-1:0]  flush_npc,
  output logic             rob_empty
);

  localparam int IDX_W = $clog2(ROB_SIZE);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ent_st_t;

  // control state
  ent_st_t          r_state [ROB_SIZE];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [TAG_W-1:0] r_count;

  // entry payload (never needs clearing: validity lives in r_state)
  logic [4:0]       r_rd        [ROB_SIZE];
  logic [XLEN-1:0]  r_pc        [ROB_SIZE];
  logic [31:0]      r_inst      [ROB_SIZE];
  logic [XLEN-1:0]  r_result    [ROB_SIZE];
  logic [XLEN-1:0]  r_npc       [ROB_SIZE];
  logic             r_pc_change [ROB_SIZE];
  logic             r_ebreak    [ROB_SIZE];
  logic             r_csr_wen   [ROB_SIZE];
  logic [11:0]      r_csr_addr  [ROB_SIZE];
  logic [XLEN-1:0]  r_csr_wdata [ROB_SIZE];

  // registered commit outputs
  logic             r_cm_valid;
  logic [4:0]       r_cm_rd;
  logic [XLEN-1:0]  r_cm_result;
  logic [XLEN-1:0]  r_cm_pc;
  logic [31:0]      r_cm_inst;
  logic             r_cm_csr_wen;
  logic [11:0]      r_cm_csr_addr;
  logic [XLEN-1:0]  r_cm_csr_wdata;
  logic             r_cm_ebreak;
  logic             r_flush_valid;
  logic [XLEN-1:0]  r_flush_npc;

  logic             w_head_done;
  logic             w_head_flush;
  logic             w_full;
  logic             w_dis_fire;
  logic [TAG_W-1:0] w_wb_dec;
  logic [IDX_W-1:0] w_wb_idx;
  logic             w_wb_hit;
  logic [XLEN:0]    w_lk1;
  logic [XLEN:0]    w_lk2;

  // Tag minus one: the low bits give the entry index, and the top bit is set
  // exactly when the tag is 0 or beyond ROB_SIZE, so it doubles as a range check.
  assign w_wb_dec = wb_dest - TAG_W'(1);
  assign w_wb_idx = w_wb_dec[IDX_W-1:0];
  assign w_wb_hit = wb_valid && !w_wb_dec[TAG_W-1] && (r_state[w_wb_idx] == ST_BUSY);

  assign w_head_done  = (r_state[r_head] == ST_DONE);
  assign w_head_flush = w_head_done && r_pc_change[r_head];
  assign w_full       = (r_count == TAG_W'(ROB_SIZE));

  // A full buffer stalls even when the head retires this cycle, and a pending
  // redirect blocks dispatch because the buffer is about to be emptied.
  assign dis_ready  = !w_full && !w_head_flush;
  assign w_dis_fire = dis_valid && dis_ready;
  assign dis_dest   = {1'b0, r_tail} + TAG_W'(1);
  assign rob_empty  = (r_count == '0);

  // Lookup result packed as {ready, value}.
  function automatic logic [XLEN:0] f_lookup(input logic [TAG_W-1:0] tag);
    logic [TAG_W-1:0] dec;
    logic [IDX_W-1:0] idx;
    logic [XLEN:0]    res;
    dec = tag - TAG_W'(1);
    idx = dec[IDX_W-1:0];
    res = '0;
    if (tag == '0) begin
      res = {1'b1, {XLEN{1'b0}}};
    end else if (!dec[TAG_W-1] && (r_state[idx] == ST_DONE)) begin
      res = {1'b1, r_result[idx]};
    end
`ifdef YSYX_ROB_WB_BYPASS_EN
    else if (w_wb_hit && (tag == wb_dest)) begin
      res = {1'b1, wb_result};
    end
`endif
    return res;
  endfunction

  assign w_lk1     = f_lookup(lk1_tag);
  assign w_lk2     = f_lookup(lk2_tag);
  assign lk1_ready = w_lk1[XLEN];
  assign lk1_value = w_lk1[XLEN-1:0];
  assign lk2_ready = w_lk2[XLEN];
  assign lk2_value = w_lk2[XLEN-1:0];

  // Control state and commit registers. Later assignments to r_state take
  // priority: a flush frees every entry, which also drops any writeback
  // landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ROB_SIZE; i++) r_state[i] <= ST_FREE;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_cm_valid     <= 1'b0;
      r_cm_rd        <= '0;
      r_cm_result    <= '0;
      r_cm_pc        <= '0;
      r_cm_inst      <= '0;
      r_cm_csr_wen   <= 1'b0;
      r_cm_csr_addr  <= '0;
      r_cm_csr_wdata <= '0;
      r_cm_ebreak    <= 1'b0;
      r_flush_valid  <= 1'b0;
      r_flush_npc    <= '0;
    end else begin
      if (w_wb_hit) r_state[w_wb_idx] <= ST_DONE;

      if (w_dis_fire) begin
        r_state[r_tail] <= ST_BUSY;
        r_tail          <= r_tail + IDX_W'(1);
      end

      r_cm_valid    <= w_head_done;
      r_flush_valid <= w_head_flush;
      if (w_head_done) begin
        r_cm_rd         <= r_rd[r_head];
        r_cm_result     <= r_result[r_head];
        r_cm_pc         <= r_pc[r_head];
        r_cm_inst       <= r_inst[r_head];
        r_cm_csr_wen    <= r_csr_wen[r_head];
        r_cm_csr_addr   <= r_csr_addr[r_head];
        r_cm_csr_wdata  <= r_csr_wdata[r_head];
        r_cm_ebreak     <= r_ebreak[r_head];
        r_state[r_head] <= ST_FREE;
        r_head          <= r_head + IDX_W'(1);
      end

      if (w_head_flush) begin
        r_flush_npc <= r_npc[r_head];
        for (int i = 0; i < ROB_SIZE; i++) r_state[i] <= ST_FREE;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_count <= r_count + {{(TAG_W-1){1'b0}}, w_dis_fire}
                           - {{(TAG_W-1){1'b0}}, w_head_done};
      end
    end
  end

  // Entry payload capture; guarded by the same accept conditions as r_state.
  always_ff @(posedge clock) begin
    if (w_dis_fire) begin
      r_rd[r_tail]   <= dis_rd;
      r_pc[r_tail]   <= dis_pc;
      r_inst[r_tail] <= dis_inst;
    end
    if (w_wb_hit) begin
      r_result[w_wb_idx]    <= wb_result;
      r_npc[w_wb_idx]       <= wb_npc;
      r_pc_change[w_wb_idx] <= wb_pc_change;
      r_ebreak[w_wb_idx]    <= wb_ebreak;
      r_csr_wen[w_wb_idx]   <= wb_csr_wen;
      r_csr_addr[w_wb_idx]  <= wb_csr_addr;
      r_csr_wdata[w_wb_idx] <= wb_csr_wdata;
    end
  end

  assign cm_valid     = r_cm_valid;
  assign cm_rd        = r_cm_rd;
  assign cm_result    = r_cm_result;
  assign cm_pc        = r_cm_pc;
  assign cm_inst      = r_cm_inst;
  assign cm_csr_wen   = r_cm_csr_wen;
  assign cm_csr_addr  = r_cm_csr_addr;
  assign cm_csr_wdata = r_cm_csr_wdata;
  assign cm_ebreak    = r_cm_ebreak;
  assign flush_valid  = r_flush_valid;
  assign flush_npc    = r_flush_npc;

endmodule

// File: tb/tb_ysyx_rob_commit.sv
// Directed bench for ysyx_rob_commit (ROB_SIZE=4, XLEN=32, TAG_W=3).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_ysyx_rob_commit;

  localparam int TAG_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             dis_valid, dis_ready;
  logic [4:0]       dis_rd;
  logic [31:0]      dis_pc, dis_inst;
  logic [TAG_W-1:0] dis_dest;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_dest;
  logic [31:0]      wb_result, wb_npc;
  logic             wb_pc_change, wb_ebreak, wb_csr_wen;
  logic [11:0]      wb_csr_addr;
  logic [31:0]      wb_csr_wdata;
  logic [TAG_W-1:0] lk1_tag, lk2_tag;
  logic             lk1_ready, lk2_ready;
  logic [31:0]      lk1_value, lk2_value;
  logic             cm_valid;
  logic [4:0]       cm_rd;
  logic [31:0]      cm_result, cm_pc, cm_inst;
  logic             cm_csr_wen;
  logic [11:0]      cm_csr_addr;
  logic [31:0]      cm_csr_wdata;
  logic             cm_ebreak;
  logic             flush_valid;
  logic [31:0]      flush_npc;
  logic             rob_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  ysyx_rob_commit #(.ROB_SIZE(4), .XLEN(32), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .dis_valid(dis_valid), .dis_ready(dis_ready), .dis_rd(dis_rd),
    .dis_pc(dis_pc), .dis_inst(dis_inst), .dis_dest(dis_dest),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result),
    .wb_npc(wb_npc), .wb_pc_change(wb_pc_change), .wb_ebreak(wb_ebreak),
    .wb_csr_wen(wb_csr_wen), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
    .lk1_tag(lk1_tag), .lk2_tag(lk2_tag),
    .lk1_ready(lk1_ready), .lk2_ready(lk2_ready),
    .lk1_value(lk1_value), .lk2_value(lk2_value),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_result(cm_result), .cm_pc(cm_pc),
    .cm_inst(cm_inst), .cm_csr_wen(cm_csr_wen), .cm_csr_addr(cm_csr_addr),
    .cm_csr_wdata(cm_csr_wdata), .cm_ebreak(cm_ebreak),
    .flush_valid(flush_valid), .flush_npc(flush_npc), .rob_empty(rob_empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [TAG_W-1:0] t, input logic [31:0] res,
                        input logic pcc, input logic [31:0] npc);
    wb_valid     = v;
    wb_dest      = t;
    wb_result    = res;
    wb_pc_change = pcc;
    wb_npc       = npc;
  endtask

  initial begin
    reset = 1'b1;
    dis_valid = 1'b0; dis_rd = '0; dis_pc = '0; dis_inst = '0;
    set_wb(1'b0, '0, '0, 1'b0, '0);
    wb_ebreak = 1'b0; wb_csr_wen = 1'b0; wb_csr_addr = '0; wb_csr_wdata = '0;
    lk1_tag = '0; lk2_tag = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    // reset state
    chk("rst_empty", rob_empty, 1);
    chk("rst_dest", dis_dest, 1);
    chk("rst_ready", dis_ready, 1);
    chk("rst_cm_valid", cm_valid, 0);
    chk("rst_flush_valid", flush_valid, 0);
    chk("rst_cm_rd", cm_rd, 0);
    chk("rst_flush_npc", flush_npc, 0);

    // fill the buffer: tags 1..4
    for (int i = 1; i <= 4; i++) begin
      dis_valid = 1'b1;
      dis_rd    = 5'(i);
      dis_pc    = 32'h8000_0000 + 32'(4 * (i - 1));
      dis_inst  = 32'h1000_0000 + 32'(i);
      #1;
      chk($sformatf("fill_dest%0d", i), dis_dest, i);
      chk($sformatf("fill_ready%0d", i), dis_ready, 1);
      tick();
    end
    dis_valid = 1'b0;
    #1;
    chk("full_ready", dis_ready, 0);
    chk("full_empty", rob_empty, 0);

    // lookups: tag 0 and a BUSY tag
    lk1_tag = 3'd0; lk2_tag = 3'd2;
    #1;
    chk("lk_tag0_ready", lk1_ready, 1);
    chk("lk_tag0_value", lk1_value, 0);
    chk("lk_busy_ready", lk2_ready, 0);
    chk("lk_busy_value", lk2_value, 0);

    // same-cycle writeback of tag 3 seen by lookup only with bypass
    lk1_tag = 3'd3;
    set_wb(1'b1, 3'd3, 32'h30, 1'b0, '0);
    #1;
`ifdef YSYX_ROB_WB_BYPASS_EN
    chk("lk_byp_ready", lk1_ready, 1);
    chk("lk_byp_value", lk1_value, 32'h30);
`else
    chk("lk_byp_ready", lk1_ready, 0);
    chk("lk_byp_value", lk1_value, 0);
`endif
    tick();
    wb_valid = 1'b0;
    #1;
    chk("lk_done_ready", lk1_ready, 1);
    chk("lk_done_value", lk1_value, 32'h30);
    chk("no_commit_head_busy", cm_valid, 0);

    // duplicate writeback to a DONE tag is ignored
    set_wb(1'b1, 3'd3, 32'hDEAD, 1'b0, '0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("dup_wb_value", lk1_value, 32'h30);

    // cycle N: writeback tag 1
    set_wb(1'b1, 3'd1, 32'h10, 1'b0, '0);
    tick();
    // N+1: writeback tag 2, try to dispatch into the full buffer while head retires
    set_wb(1'b1, 3'd2, 32'h20, 1'b0, '0);
    dis_valid = 1'b1; dis_rd = 5'd5; dis_pc = 32'h8000_0010; dis_inst = 32'h1000_0005;
    #1;
    chk("n1_cm_valid", cm_valid, 0);
    chk("n1_full_commit_ready", dis_ready, 0);
    tick();
    // N+2: first commit, dispatch now accepted with wrapped tag
    wb_valid = 1'b0;
    #1;
    chk("c1_valid", cm_valid, 1);
    chk("c1_rd", cm_rd, 1);
    chk("c1_result", cm_result, 32'h10);
    chk("c1_pc", cm_pc, 32'h8000_0000);
    chk("c1_inst", cm_inst, 32'h1000_0001);
    chk("wrap_ready", dis_ready, 1);
    chk("wrap_dest", dis_dest, 1);
    tick();
    dis_valid = 1'b0;
    #1;
    chk("c2_valid", cm_valid, 1);
    chk("c2_rd", cm_rd, 2);
    chk("c2_result", cm_result, 32'h20);
    chk("post_wrap_dest", dis_dest, 2);
    tick();
    chk("c3_valid", cm_valid, 1);
    chk("c3_rd", cm_rd, 3);
    chk("c3_result", cm_result, 32'h30);
    tick();
    chk("c4_idle_valid", cm_valid, 0);
    chk("c4_hold_rd", cm_rd, 3);
    chk("c4_hold_result", cm_result, 32'h30);

    // flush: younger tag 1 (rd 5) redirects, older tag 4 (rd 4) retires first
    set_wb(1'b1, 3'd1, 32'h50, 1'b1, 32'h8000_0100);
    tick();
    set_wb(1'b1, 3'd4, 32'h40, 1'b0, '0);
    #1;
    chk("fl_ready_before", dis_ready, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("fl_wait_valid", cm_valid, 0);
    tick();
    chk("fl_c1_valid", cm_valid, 1);
    chk("fl_c1_rd", cm_rd, 4);
    chk("fl_c1_result", cm_result, 32'h40);
    chk("fl_c1_flush", flush_valid, 0);
    dis_valid = 1'b1; dis_rd = 5'd7;
    #1;
    chk("fl_pending_ready", dis_ready, 0);
    tick();
    dis_valid = 1'b0;
    #1;
    chk("fl_c2_valid", cm_valid, 1);
    chk("fl_c2_rd", cm_rd, 5);
    chk("fl_c2_result", cm_result, 32'h50);
    chk("fl_flush_valid", flush_valid, 1);
    chk("fl_flush_npc", flush_npc, 32'h8000_0100);
    chk("fl_empty", rob_empty, 1);
    chk("fl_dest", dis_dest, 1);
    tick();
    chk("fl_after_flush", flush_valid, 0);
    chk("fl_after_cm", cm_valid, 0);
    chk("fl_after_empty", rob_empty, 1);

    // mid-operation reset with 3 entries, head DONE about to commit
    for (int i = 0; i < 3; i++) begin
      dis_valid = 1'b1; dis_rd = 5'(8 + i);
      #1;
      chk($sformatf("rs_dest%0d", i), dis_dest, i + 1);
      tick();
    end
    dis_valid = 1'b0;
    set_wb(1'b1, 3'd1, 32'h77, 1'b0, '0);
    tick();
    wb_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lk2_tag = 3'd2;
    #1;
    chk("rs_empty", rob_empty, 1);
    chk("rs_cm_valid", cm_valid, 0);
    chk("rs_flush_valid", flush_valid, 0);
    chk("rs_ready", dis_ready, 1);
    chk("rs_dest", dis_dest, 1);
    chk("rs_cm_rd", cm_rd, 0);
    chk("rs_lk_ready", lk2_ready, 0);
    tick();
    chk("rs_no_late_commit", cm_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
